// File: rtl/sys_lsu.sv
// sys_lsu: RV32 load/store unit between execute stage and sys_mem.
// Optional feature macro SYS_LSU_FAULT_CHECK_EN enables alignment, bounds and funct3 fault checking.
package sys;
    typedef struct packed {
        logic        en;
        logic [31:0] addr;
        logic [2:0]  size;
    } mem_read_req_t;

    typedef struct packed {
        logic        done;
        logic [31:0] data;
    } mem_read_rsp_t;

    typedef struct packed {
        logic        en;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
    } mem_write_req_t;

    typedef struct packed {
        logic done;
    } mem_write_rsp_t;
endpackage

module sys_lsu #(
    parameter int mem_size    = 1024,
    parameter int mem_latency = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_store,
    input  logic [2:0]          req_funct3,
    input  logic [31:0]         req_addr,
    input  logic [31:0]         req_wdata,
    output logic                rsp_valid,
    output logic [31:0]         rsp_data,
    output logic                rsp_fault,
    output sys::mem_read_req_t  mem_read_req,
    input  sys::mem_read_rsp_t  mem_read_rsp,
    output sys::mem_write_req_t mem_write_req,
    input  sys::mem_write_rsp_t mem_write_rsp
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state, state_next;
    logic        store;
    logic [2:0]  funct3;
    logic [3:0]  cnt;
    logic [2:0]  f3_eff, size;
    logic        legal, fault, accept, done;

    if (mem_latency < 1 || mem_latency > 15 || mem_size < 4) begin : g_bad_cfg
        $error("sys_lsu: mem_latency must be 1..15 and mem_size at least 4");
    end

    // Legal RV32 funct3: loads 000/001/010/100/101, stores 000/001/010.
    assign legal  = req_funct3[1:0] != 2'b11 && !(req_funct3[2] && (req_store || req_funct3[1]));
    assign accept = req_valid && req_ready;
    assign done   = store ? mem_write_rsp.done : mem_read_rsp.done;
    assign size   = f3_eff[1:0] == 2'b00 ? 3'd1 : f3_eff[1:0] == 2'b01 ? 3'd2 : 3'd4;
    assign req_ready = state == IDLE && rst_n;

`ifdef SYS_LSU_FAULT_CHECK_EN
    assign f3_eff = req_funct3;
    // Bounds sum is 33 bits wide so a high address cannot wrap into range.
    assign fault  = !legal
                 || (size == 3'd2 && req_addr[0])
                 || (size == 3'd4 && req_addr[1:0] != 2'b00)
                 || ({1'b0, req_addr} + {30'b0, size} > 33'(mem_size));
`else
    assign f3_eff = legal ? req_funct3 : 3'b010;
    assign fault  = 1'b0;
`endif

    function automatic logic [31:0] ext(input logic [2:0] f3, input logic [31:0] d);
        return f3 == 3'b000 ? {{24{d[7]}}, d[7:0]}
             : f3 == 3'b001 ? {{16{d[15]}}, d[15:0]}
             : f3 == 3'b100 ? {24'b0, d[7:0]}
             : f3 == 3'b101 ? {16'b0, d[15:0]}
             : d;
    endfunction

    // Next-state selection; faults skip memory entirely.
    always_comb begin
        state_next = state;
        state_next = state == IDLE  ? (accept ? (fault ? RESP : ISSUE) : IDLE)
                   : state == ISSUE ? WAIT
                   : state == WAIT  ? ((cnt <= 4'd1 && done) ? RESP : WAIT)
                   : IDLE;
    end

    // State, request capture, memory request pulses, latency counter and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            store         <= 1'b0;
            funct3        <= 3'b0;
            cnt           <= 4'd0;
            rsp_valid     <= 1'b0;
            rsp_data      <= 32'b0;
            rsp_fault     <= 1'b0;
            mem_read_req  <= '0;
            mem_write_req <= '0;
        end else begin
            state            <= state_next;
            rsp_valid        <= state_next == RESP;
            mem_read_req.en  <= 1'b0;
            mem_write_req.en <= 1'b0;
            if (state == IDLE && accept) begin
                store     <= req_store;
                funct3    <= f3_eff;
                rsp_fault <= fault;
                rsp_data  <= 32'b0;
                if (!fault) begin
                    mem_read_req  <= '{en: !req_store, addr: req_addr, size: size};
                    mem_write_req <= '{en: req_store, addr: req_addr, size: size, data: req_wdata};
                end
            end
            if (state == ISSUE) cnt <= 4'(mem_latency);
            if (state == WAIT && cnt > 4'd1) cnt <= cnt - 4'd1;
            if (state == WAIT && state_next == RESP && !store) rsp_data <= ext(funct3, mem_read_rsp.data);
        end
    end
endmodule

// File: tb/tb_sys_lsu.sv
// tb_sys_lsu: scoreboard bench for sys_lsu at latency 1 (port 0) and latency 3 (port 1) with a shared byte memory model.
module tb_sys_lsu;
    typedef struct {
        int          port;
        bit          store;
        int          issue;
        int          rsp;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rv[2], rs[2], rdy[2], vld[2], flt[2];
    logic [2:0]  rf[2];
    logic [31:0] ra[2], rw[2], dat[2];
    sys::mem_read_req_t  rreq[2];
    sys::mem_read_rsp_t  rrsp[2];
    sys::mem_write_req_t wreq[2];
    sys::mem_write_rsp_t wrsp[2];
    logic [7:0]  mem [1024] = '{default: 8'h00};
    int          rcnt[2], wcnt[2];
    logic [31:0] rdat[2];
    int   cyc = 0, checks = 0, errors = 0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sys_lsu #(.mem_size(1024), .mem_latency(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_ready(rdy[0]), .req_store(rs[0]),
        .req_funct3(rf[0]), .req_addr(ra[0]), .req_wdata(rw[0]), .rsp_valid(vld[0]),
        .rsp_data(dat[0]), .rsp_fault(flt[0]), .mem_read_req(rreq[0]), .mem_read_rsp(rrsp[0]),
        .mem_write_req(wreq[0]), .mem_write_rsp(wrsp[0]));

    sys_lsu #(.mem_size(1024), .mem_latency(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_ready(rdy[1]), .req_store(rs[1]),
        .req_funct3(rf[1]), .req_addr(ra[1]), .req_wdata(rw[1]), .rsp_valid(vld[1]),
        .rsp_data(dat[1]), .rsp_fault(flt[1]), .mem_read_req(rreq[1]), .mem_read_rsp(rrsp[1]),
        .mem_write_req(wreq[1]), .mem_write_rsp(wrsp[1]));

    function automatic logic [31:0] rd(input logic [31:0] a, input logic [2:0] sz);
        logic [31:0] d = 32'b0;
        for (int i = 0; i < 4; i++) if (i < int'(sz)) d[8*i +: 8] = mem[10'(a + 32'(i))];
        return d;
    endfunction

    // Little-endian memory: done is high in the cycle mem_latency after the enable was sampled.
    always @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (rcnt[p] > 0) rcnt[p] <= rcnt[p] - 1;
            if (wcnt[p] > 0) wcnt[p] <= wcnt[p] - 1;
            if (rreq[p].en) begin
                rcnt[p] <= p == 0 ? 1 : 3;
                rdat[p] <= rd(rreq[p].addr, rreq[p].size);
            end
            if (wreq[p].en) begin
                wcnt[p] <= p == 0 ? 1 : 3;
                for (int i = 0; i < 4; i++)
                    if (i < int'(wreq[p].size)) mem[10'(wreq[p].addr + 32'(i))] <= wreq[p].data[8*i +: 8];
            end
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rrsp[p].done = rcnt[p] == 1;
            rrsp[p].data = rdat[p];
            wrsp[p].done = wcnt[p] == 1;
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, want, cyc);
        end
    endtask

    // Monitor: checks every memory enable against the pending entry and pops on each response.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            for (int p = 0; p < 2; p++) begin
                if (rreq[p].en || wreq[p].en) begin
                    if (q.size() == 0 || q[0].port != p || q[0].issue < 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_en port %0d cycle %0d", p, cyc);
                    end else begin
                        chk("issue_cycle", 32'(cyc), 32'(q[0].issue));
                        chk("en_kind", 32'(wreq[p].en), 32'(q[0].store));
                        chk("en_addr", q[0].store ? wreq[p].addr : rreq[p].addr, q[0].addr);
                        chk("en_size", 32'(q[0].store ? wreq[p].size : rreq[p].size), 32'(q[0].size));
                        if (q[0].store) chk("en_wdata", wreq[p].data, q[0].wdata);
                    end
                end
                if (vld[p]) begin
                    if (q.size() == 0 || q[0].port != p) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp port %0d cycle %0d", p, cyc);
                    end else begin
                        e = q.pop_front();
                        chk("rsp_cycle", 32'(cyc), 32'(e.rsp));
                        chk("rsp_data", dat[p], e.data);
                        chk("rsp_fault", 32'(flt[p]), 32'(e.fault));
                    end
                end
            end
        end
    end

    task automatic send(input int p, input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] ed, input bit ef, input bit hold);
        exp_t e;
        int lat = p == 0 ? 1 : 3;
        for (int i = 0; i < 20 && !rdy[p]; i++) @(negedge clk);
        chk("ready_before", 32'(rdy[p]), 32'd1);
        e.port  = p;
        e.store = st;
        e.addr  = a;
        e.wdata = wd;
        e.data  = ed;
        e.fault = ef;
        e.size  = f3[1:0] == 2'b00 ? 3'd1 : f3[1:0] == 2'b01 ? 3'd2 : 3'd4;
        e.issue = ef ? -1 : cyc + 1;
        e.rsp   = ef ? cyc + 1 : cyc + 2 + lat;
        q.push_back(e);
        rv[p] = 1'b1;
        rs[p] = st;
        rf[p] = f3;
        ra[p] = a;
        rw[p] = wd;
        @(negedge clk);
        rv[p] = hold;
        ra[p] = 32'h20;
        for (int i = 0; i < 40 && q.size() != 0; i++) begin
            chk("ready_busy", 32'(rdy[p]), 32'd0);
            @(negedge clk);
        end
        rv[p] = 1'b0;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout port %0d cycle %0d", p, cyc);
            q.delete();
        end
        @(negedge clk);
        chk("ready_after", 32'(rdy[p]), 32'd1);
    endtask

    initial begin
        exp_t e;
        for (int p = 0; p < 2; p++) begin
            rv[p] = 1'b0;
            rs[p] = 1'b0;
            rf[p] = 3'b0;
            ra[p] = 32'b0;
            rw[p] = 32'b0;
        end
        repeat (2) @(negedge clk);
        chk("reset_ready", 32'(rdy[0]), 32'd0);
        chk("reset_valid", 32'(vld[0]), 32'd0);
        chk("reset_data", dat[0], 32'd0);
        chk("reset_fault", 32'(flt[0]), 32'd0);
        chk("reset_rreq", 32'(rreq[0] != '0), 32'd0);
        chk("reset_wreq", 32'(wreq[0] != '0), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(rdy[0]), 32'd1);

        send(0, 1, 3'b010, 32'h10, 32'h8000_00F0, 32'h0, 0, 0);
        send(0, 0, 3'b000, 32'h10, 32'h0, 32'hFFFF_FFF0, 0, 0);
        send(0, 0, 3'b100, 32'h10, 32'h0, 32'h0000_00F0, 0, 0);
        send(0, 0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FF80, 0, 0);
        send(0, 0, 3'b101, 32'h12, 32'h0, 32'h0000_8000, 0, 0);
        send(0, 0, 3'b001, 32'h12, 32'h0, 32'hFFFF_8000, 0, 0);
        send(0, 0, 3'b001, 32'h10, 32'h0, 32'h0000_00F0, 0, 0);
        send(0, 0, 3'b010, 32'h10, 32'h0, 32'h8000_00F0, 0, 0);
`ifdef SYS_LSU_FAULT_CHECK_EN
        send(0, 0, 3'b010, 32'h12, 32'h0, 32'h0, 1, 0);
        send(0, 1, 3'b001, 32'h11, 32'h0, 32'h0, 1, 0);
        send(0, 0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 0);
        send(0, 0, 3'b010, 32'h3FE, 32'h0, 32'h0, 1, 0);
        send(0, 0, 3'b000, 32'h400, 32'h0, 32'h0, 1, 0);
`else
        send(0, 0, 3'b010, 32'h12, 32'h0, 32'h0000_8000, 0, 0);
        send(0, 1, 3'b001, 32'h11, 32'h0, 32'h0, 0, 0);
        send(0, 0, 3'b011, 32'h10, 32'h0, 32'h8000_00F0, 0, 0);
`endif
        send(0, 0, 3'b010, 32'h3FC, 32'h0, 32'h0, 0, 0);
        send(0, 1, 3'b000, 32'h3FF, 32'h1234_56A5, 32'h0, 0, 0);
        send(0, 0, 3'b000, 32'h3FF, 32'h0, 32'hFFFF_FFA5, 0, 0);
        send(0, 0, 3'b100, 32'h3FF, 32'h0, 32'h0000_00A5, 0, 0);
        send(1, 0, 3'b010, 32'h10, 32'h0, 32'h8000_00F0, 0, 1);

        e.port  = 0;
        e.store = 0;
        e.addr  = 32'h10;
        e.size  = 3'd4;
        e.wdata = 32'h0;
        e.data  = 32'h8000_00F0;
        e.fault = 0;
        e.issue = cyc + 1;
        e.rsp   = cyc + 3;
        q.push_back(e);
        rv[0] = 1'b1;
        rs[0] = 1'b0;
        rf[0] = 3'b010;
        ra[0] = 32'h10;
        @(negedge clk);
        rv[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(vld[0]), 32'd0);
        chk("abort_data", dat[0], 32'd0);
        chk("abort_fault", 32'(flt[0]), 32'd0);
        chk("abort_ready", 32'(rdy[0]), 32'd0);
        chk("abort_rreq", 32'(rreq[0] != '0), 32'd0);
        chk("abort_wreq", 32'(wreq[0] != '0), 32'd0);
        q.delete();
        @(negedge clk);
        chk("abort_valid_held", 32'(vld[0]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_abort", 32'(rdy[0]), 32'd1);
        send(0, 0, 3'b010, 32'h10, 32'h0, 32'h8000_00F0, 0, 0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sys_lsu.md
# sys_lsu

Load/store unit between the core's execute stage and `sys_mem`. Accepts one RV32 load or store per transaction over a valid/ready handshake and checks alignment and bounds. Drives a single `sys_mem` read port and write port, waits the fixed memory latency, then returns sign- or zero-extended load data or a fault as a one-cycle response pulse.

## Interface
- `mem_size`, 1024: bytes in the attached `sys_mem`; used for bounds checking.
- `mem_latency`, 1: cycles from the request-sampling edge until response data is valid; range 1..15.
- `clk` in 1: clock, posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: core request valid.
- `req_ready` out 1: `state==IDLE && rst_n`.
- `req_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32 funct3.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, low bytes used.
- `rsp_valid` out 1: one-cycle response pulse; no backpressure.
- `rsp_data` out 32: extended load data; 0 for stores and faults.
- `rsp_fault` out 1: misaligned, out-of-range or illegal funct3.
- `mem_read_req` out `sys::mem_read_req_t`: {en, addr, size}.
- `mem_read_rsp` in `sys::mem_read_rsp_t`: {done, data}.
- `mem_write_req` out `sys::mem_write_req_t`: {en, addr, size, data}.
- `mem_write_rsp` in `sys::mem_write_rsp_t`: {done}.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: on `req_valid && req_ready`, register store flag, funct3, addr and wdata.
  - Access size in bytes: 1 for funct3[1:0]=00, 2 for 01, 4 for 10.
  - Fault conditions: illegal funct3; addr[0]≠0 for size 2; addr[1:0]≠0 for size 4; addr+size > `mem_size`, computed 33-bit with no wrap.
  - Fault → RESP with fault latched. Otherwise → ISSUE.
- ISSUE: for exactly one cycle, assert `en` on the read or write request with the registered addr and size.
  - Write data is `req_wdata` unmodified; `sys_mem` takes the low `size` bytes.
  - Then load the wait counter with `mem_latency`; → WAIT.
- WAIT: decrement the counter each cycle.
  - When the counter reaches 1 and the relevant `done`=1: capture `mem_read_rsp.data[31:0]` (loads) and go to RESP.
  - If `done`=0 at that point, stay in WAIT until `done`=1.
- Load extension:
  - LB: sign-extend bit 7.
  - LH: sign-extend bit 15.
  - LBU/LHU: zero-extend.
  - LW: pass through.
- RESP: `rsp_valid`=1 for one cycle with registered data and fault; → IDLE.
- Request enables are 0 in every state except ISSUE.
- Reset values: state IDLE; `rsp_valid`, `rsp_data`, `rsp_fault` = 0; all `mem_*_req` fields = 0; counter = 0.
- Reset mid-transaction (`rst_n` low in any state) aborts immediately:
  - enables drop asynchronously;
  - no `rsp_valid` is produced;
  - the write may or may not have reached memory.
- `req_valid` asserted outside IDLE is ignored and not accepted.

## Timing
- Accept at cycle T.
- Non-faulting access: ISSUE at T+1; WAIT covers T+2 .. T+1+`mem_latency`; `rsp_valid` at T+2+`mem_latency` (T+3 at default).
- Faulting access: `rsp_valid` at T+1, with no memory enable at any point.
- Back-to-back: next accept no earlier than the cycle after RESP, i.e. T+4 at default latency.
- All outputs are registered except `req_ready`.

## Configuration
- `SYS_LSU_FAULT_CHECK_EN` defined: full alignment, bounds and funct3 checking as above.
- Undefined:
  - No checks; `rsp_fault` tied 0.
  - Every request goes through ISSUE.
  - Illegal funct3 is treated as LW.
  - Address legality becomes the caller's responsibility; `sys_mem` aborts simulation out of range.

## Test plan
- SW addr 0x10, wdata 0x8000_00F0 → write en only in T+1, addr 0x10, size 4; `rsp_valid` at T+3 with data 0, fault 0.
- After that store, LB 0x10 → 0xFFFF_FFF0; LBU 0x10 → 0x0000_00F0; LB 0x13 → 0xFFFF_FF80; LHU 0x12 → 0x0000_8000; LW 0x10 → 0x8000_00F0.
- LW 0x12, SH 0x11, funct3 011 load, and LW 0x3FE with `mem_size`=1024 → `rsp_valid` and `rsp_fault`=1 at T+1, `rsp_data`=0, no memory enable.
- `mem_latency`=3, LW 0x10 → `rsp_valid` exactly at T+5; `req_ready`=0 from T+1 through T+5.
- Pull `rst_n` low during WAIT → all outputs 0 in the same cycle, no `rsp_valid`; after release, `req_ready`=1 and LW 0x10 completes normally.
- With `SYS_LSU_FAULT_CHECK_EN` undefined, LW 0x12 → ISSUE at T+1 with addr 0x12, `rsp_fault`=0 at T+3.
